// File: rtl/gray_world_sequencer.sv
// Gray-world statistics/apply sequencer.
// Accumulates per-channel sums over one frame, hands off to a gain calculator,
// then gates the next frame through the gain-correction datapath.

// One colour channel's frame accumulator: load starts a new sum, add extends it.
module gws_acc_lane #(
  parameter int ACC_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             add,
  input  logic [7:0]       din,
  output logic [ACC_W-1:0] acc
);
  logic [ACC_W-1:0] din_ext;
  assign din_ext = ACC_W'(din);

  // Load takes priority so an early SOF restarts the sum on its own pixel.
  always_ff @(posedge clk) begin
    if (rst)       acc <= '0;
    else if (load) acc <= din_ext;
    else if (add)  acc <= acc + din_ext;
  end
endmodule

module gray_world_sequencer #(
  parameter int NROWS = 349,
  parameter int NCOLS = 349,
  parameter int ACC_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             in_sof,
  input  logic             in_dval,
  input  logic [23:0]      in_pixel,
  output logic [ACC_W-1:0] acc_r,
  output logic [ACC_W-1:0] acc_g,
  output logic [ACC_W-1:0] acc_b,
  output logic             calc_start,
  input  logic             calc_done,
  output logic             apply_en,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic             err
);
  localparam int TOTAL = NROWS * NCOLS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SOF, S_ACCUM, S_CALC, S_WAIT_APPLY, S_APPLY
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pix_cnt;
  logic             sof_px, last_px, acc_load, acc_add;

  assign sof_px  = in_sof & in_dval;
  // Pixel that brings the count up to a full frame.
  assign last_px = in_dval && (pix_cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; an SOF in ACCUM restarts rather than completes the frame.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (start)              state_nxt = S_WAIT_SOF;
      S_WAIT_SOF:   if (sof_px)             state_nxt = S_ACCUM;
      S_ACCUM:      if (!in_sof && last_px) state_nxt = S_CALC;
      S_CALC:       if (calc_done)          state_nxt = S_WAIT_APPLY;
      S_WAIT_APPLY: if (sof_px)             state_nxt = S_APPLY;
      S_APPLY:      if (last_px)            state_nxt = cont ? S_WAIT_SOF : S_IDLE;
      default:                              state_nxt = S_IDLE;
    endcase
  end

  // Outputs and accumulator controls decoded from the current state.
  always_comb begin
    busy       = (state != S_IDLE);
    apply_en   = (state == S_APPLY) || ((state == S_WAIT_APPLY) && sof_px);
    frame_done = (state == S_APPLY) && last_px;
    acc_load   = ((state == S_WAIT_SOF) || (state == S_ACCUM)) && sof_px;
    acc_add    = (state == S_ACCUM) && in_dval && !in_sof;
  end

  // Pixel counter, completed-frame counter, sticky error and calc handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt    <= '0;
      frame_cnt  <= '0;
      err        <= 1'b0;
      calc_start <= 1'b0;
    end else begin
      calc_start <= (state == S_ACCUM) && !in_sof && last_px;
      case (state)
        S_WAIT_SOF, S_WAIT_APPLY: if (sof_px) pix_cnt <= CNT_W'(1);
        S_ACCUM: begin
          if (sof_px) begin
            err     <= 1'b1;
            pix_cnt <= CNT_W'(1);
          end else if (in_dval) begin
            pix_cnt <= last_px ? '0 : pix_cnt + CNT_W'(1);
          end
        end
        S_APPLY: begin
          if (sof_px) err <= 1'b1;
          if (last_px) begin
            pix_cnt   <= '0;
            frame_cnt <= frame_cnt + 16'd1;
          end else if (in_dval) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
          end
        end
        default: pix_cnt <= '0;
      endcase
    end
  end

  logic [2:0][7:0]       chan;
  logic [2:0][ACC_W-1:0] acc;
  assign chan = in_pixel;   // [2]=R, [1]=G, [0]=B

  for (genvar c = 0; c < 3; c++) begin : g_lane
    gws_acc_lane #(.ACC_W(ACC_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (acc_load),
      .add  (acc_add),
      .din  (chan[c]),
      .acc  (acc[c])
    );
  end

  assign acc_r = acc[2];
  assign acc_g = acc[1];
  assign acc_b = acc[0];
endmodule

// File: tb/tb_gray_world_sequencer.sv
// Randomised bench for gray_world_sequencer with a 4x4 frame.
// Expected values come from a frame-level model: sums of the pixels since the
// last SOF, a frame counter and a sticky error flag.
module tb_gray_world_sequencer;
  localparam int NROWS = 4;
  localparam int NCOLS = 4;
  localparam int NPIX  = NROWS * NCOLS;
  localparam int ACC_W = 12;

  logic             clk = 1'b0;
  logic             rst, start, cont, in_sof, in_dval, calc_done;
  logic [23:0]      in_pixel;
  logic [ACC_W-1:0] acc_r, acc_g, acc_b;
  logic             calc_start, apply_en, busy, frame_done, err;
  logic [15:0]      frame_cnt;

  gray_world_sequencer #(.NROWS(NROWS), .NCOLS(NCOLS), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont       (cont),
    .in_sof     (in_sof),
    .in_dval    (in_dval),
    .in_pixel   (in_pixel),
    .acc_r      (acc_r),
    .acc_g      (acc_g),
    .acc_b      (acc_b),
    .calc_start (calc_start),
    .calc_done  (calc_done),
    .apply_en   (apply_en),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          sr, sg, sb;          // model sums
  logic [15:0] exp_fc;
  logic        exp_err;
  logic        ae, fd;              // comb outputs sampled mid-cycle

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one cycle of pixel-bus activity, sampling comb outputs at the negedge.
  task automatic send(input logic s, input logic d, input logic [23:0] p);
    in_sof = s; in_dval = d; in_pixel = p;
    @(negedge clk);
    ae = apply_en; fd = frame_done;
    @(posedge clk); #1;
    in_sof = 1'b0; in_dval = 1'b0;
  endtask

  task automatic chk_acc(input string tag);
    chk({tag, "_r"}, 32'(acc_r), 32'(sr));
    chk({tag, "_g"}, 32'(acc_g), 32'(sg));
    chk({tag, "_b"}, 32'(acc_b), 32'(sb));
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b1; calc_done = 1'b1;   // rst must win over both
    tick(); tick();
    rst = 1'b0; start = 1'b0; calc_done = 1'b0;
    sr = 0; sg = 0; sb = 0; exp_fc = '0; exp_err = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cs", 32'(calc_start), 0);
    chk("rst_fc", 32'(frame_cnt), 0);
    chk("rst_err", 32'(err), 0);
    chk_acc("rst_acc");
  endtask

  // One statistics+apply sequence.
  //  gap:    invalid cycles before each valid pixel
  //  early:  ACCUM pixel index carrying a premature SOF (0 = none)
  //  cdly:   cycles after calc_start before calc_done (0 = same cycle)
  //  ap_sof: APPLY pixel index carrying a mid-frame SOF (0 = none)
  //  abort:  APPLY pixel index on which rst is raised (0 = none)
  task automatic seq(input bit do_start, input bit use_cont, input bit fixed,
                     input logic [23:0] fixval, input int gap, input int early,
                     input int cdly, input int ap_sof, input int abort);
    int n, k;
    logic [23:0] pv;
    logic s;
    if (do_start) begin
      start = 1'b1; tick(); start = 1'b0;
      chk("start_busy", 32'(busy), 1);
    end
    // Non-SOF pixels while waiting for a frame start are ignored.
    repeat (2) send(1'b0, 1'b1, 24'($urandom));
    n = 0; k = 0;
    while (n < NPIX) begin
      repeat (gap) begin
        send(1'($urandom), 1'b0, 24'($urandom));
        chk("acc_gap_cs", 32'(calc_start), 0);
      end
      k++;
      pv = fixed ? fixval : 24'($urandom);
      s  = (k == 1) || (k == early);
      if (s) begin
        if (k != 1) exp_err = 1'b1;
        sr = 0; sg = 0; sb = 0; n = 0;
      end
      sr += int'(pv[23:16]); sg += int'(pv[15:8]); sb += int'(pv[7:0]);
      n++;
      send(s, 1'b1, pv);
      if (n < NPIX) chk("acc_cs", 32'(calc_start), 0);
    end
    chk("calc_start", 32'(calc_start), 1);
    chk_acc("acc");
    chk("acc_err", 32'(err), 32'(exp_err));
    // Gain calculation; pixel traffic here must not disturb the sums.
    for (int d = 0; d < cdly; d++) begin
      send(1'b0, 1'($urandom), 24'($urandom));
      chk("calc_cs", 32'(calc_start), 0);
      chk("calc_busy", 32'(busy), 1);
    end
    calc_done = 1'b1; tick(); calc_done = 1'b0;
    chk("post_calc_cs", 32'(calc_start), 0);
    chk_acc("calc_hold");
    // Apply frame.
    cont = use_cont;
    repeat (2) begin
      send(1'b0, 1'b1, 24'($urandom));
      chk("wait_ae", 32'(ae), 0);
    end
    for (int i = 1; i <= NPIX; i++) begin
      repeat (gap) begin
        send(1'b0, 1'b0, 24'($urandom));
        chk("gap_ae", 32'(ae), (i > 1) ? 1 : 0);
        chk("gap_fd", 32'(fd), 0);
      end
      if (i == abort) begin
        rst = 1'b1;
        send(1'b0, 1'b1, 24'($urandom));
        rst = 1'b0;
        exp_fc = '0; exp_err = 1'b0; sr = 0; sg = 0; sb = 0;
        in_sof = 1'b1; in_dval = 1'b1; #1;
        chk("abort_ae", 32'(apply_en), 0);
        in_sof = 1'b0; in_dval = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_fc", 32'(frame_cnt), 0);
        chk("abort_err", 32'(err), 0);
        chk_acc("abort_acc");
        repeat (3) begin
          calc_done = 1'b1; tick(); calc_done = 1'b0; tick();
          chk("abort_cd_busy", 32'(busy), 0);
          chk("abort_cd_cs", 32'(calc_start), 0);
        end
        return;
      end
      if (i == ap_sof) exp_err = 1'b1;
      send((i == 1) || (i == ap_sof), 1'b1, 24'($urandom));
      chk("apply_en", 32'(ae), 1);
      chk("frame_done", 32'(fd), (i == NPIX) ? 1 : 0);
    end
    exp_fc = exp_fc + 16'd1;
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    chk("end_busy", 32'(busy), 32'(use_cont));
    chk("end_err", 32'(err), 32'(exp_err));
    chk_acc("end_acc");
  endtask

  initial begin
    bit prev_cont;
    rst = 1'b1; start = 1'b0; cont = 1'b0; in_sof = 1'b0; in_dval = 1'b0;
    in_pixel = '0; calc_done = 1'b0;
    do_reset();

    // Fixed-pattern sums, calc_done three cycles later, single-shot.
    seq(1, 0, 1, 24'h102030, 0, 0, 3, 0, 0);
    chk("fix_r", 32'(acc_r), 32'h100);
    chk("fix_g", 32'(acc_g), 32'h200);
    chk("fix_b", 32'(acc_b), 32'h300);
    // Same sums with 1-of-3 valid, calc_done in the calc_start cycle.
    seq(1, 0, 1, 24'h102030, 2, 0, 0, 0, 0);
    // Random pixels with gaps.
    seq(1, 0, 0, 24'h0, 2, 0, 1, 0, 0);
    // Early SOF at pixel 7 of accumulation.
    seq(1, 0, 0, 24'h0, 0, 7, 2, 0, 0);
    chk("early_err", 32'(err), 1);

    // Continuous mode, full-scale pixels, from a clean reset.
    do_reset();
    seq(1, 1, 1, 24'hFFFFFF, 0, 0, 2, 0, 0);
    seq(0, 1, 1, 24'hFFFFFF, 0, 0, 1, 0, 0);
    chk("cont_r", 32'(acc_r), 32'hFF0);
    chk("cont_fc", 32'(frame_cnt), 2);
    chk("cont_busy", 32'(busy), 1);
    seq(0, 0, 0, 24'h0, 1, 0, 0, 5, 0);   // mid-frame SOF in apply, back to IDLE

    // Reset at pixel 9 of apply.
    seq(1, 0, 0, 24'h0, 0, 0, 1, 0, 9);

    // Random sequences.
    prev_cont = 1'b0;
    for (int r = 0; r < 8; r++) begin
      bit c;
      c = (r == 7) ? 1'b0 : 1'($urandom);
      seq(!prev_cont, c, 0, 24'h0, $urandom_range(0, 2),
          ($urandom_range(0, 3) == 0) ? $urandom_range(2, NPIX) : 0,
          $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0) ? $urandom_range(2, NPIX) : 0, 0);
      prev_cont = c;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gray_world_sequencer.md
GRAY_WORLD_SEQUENCER -- requirements
Module: gray_world_sequencer

Interface
REQ-001 Parameter NROWS, default 349: rows per frame.
REQ-002 Parameter NCOLS, default 349: pixels per row.
REQ-003 Parameter ACC_W, default 25: per-channel accumulator width. It shall be at least 8 + ceil(log2(NROWS*NCOLS)).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a statistics+apply sequence; ignored unless IDLE.
REQ-007 cont  input  1  continuous mode; sampled at end of each apply frame.
REQ-008 in_sof  input  1  start-of-frame marker, qualified by in_dval.
REQ-009 in_dval  input  1  pixel valid.
REQ-010 in_pixel  input  24  {R[23:16], G[15:8], B[7:0]}.
REQ-011 acc_r, acc_g, acc_b  output  ACC_W each  per-channel frame sums.
REQ-012 calc_start  output  1  one-cycle pulse to the gain calculator.
REQ-013 calc_done  input  1  gain calculator completion; honoured only in CALC.
REQ-014 apply_en  output  1  qualifies pixels for the gain-correction datapath.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  one-cycle pulse on the last applied pixel.
REQ-017 frame_cnt  output  16  completed apply frames, wraps 0xFFFF->0.
REQ-018 err  output  1  sticky flag for an early in_sof.

Function
REQ-019 States shall be IDLE, WAIT_SOF, ACCUM, CALC, WAIT_APPLY and APPLY, with a single pixel counter pix_cnt in [0, NROWS*NCOLS-1].
REQ-020 IDLE: when start=1, the block shall go to WAIT_SOF.
REQ-021 WAIT_SOF: a pixel with in_sof&in_dval shall load acc_* with that pixel's R/G/B, set pix_cnt=1, and enter ACCUM; pixels without in_sof shall be ignored.
REQ-022 ACCUM: each in_dval shall add R/G/B, zero-extended, to acc_*, and increment pix_cnt; in_dval=0 cycles hold all values.
REQ-023 ACCUM: the pixel that makes the count equal NROWS*NCOLS shall be added, then the state goes to CALC with calc_start=1 for exactly the next cycle.
REQ-024 ACCUM: an in_sof&in_dval arriving before the count completes shall set err, reload acc_* with that pixel, and set pix_cnt=1; the state stays ACCUM.
REQ-025 CALC: acc_* shall be held stable; calc_done=1 shall move the state to WAIT_APPLY.
REQ-026 calc_done shall be ignored outside CALC, and calc_done in the calc_start cycle shall be accepted.
REQ-027 WAIT_APPLY: apply_en = in_sof & in_dval combinationally; on that pixel the state goes to APPLY with pix_cnt=1.
REQ-028 APPLY: apply_en shall be 1.
REQ-029 APPLY: in_dval shall increment pix_cnt; a mid-frame in_sof shall set err without restarting.
REQ-030 APPLY: on the last pixel (count reaches NROWS*NCOLS), frame_done shall be 1 combinationally that cycle and frame_cnt shall increment.
REQ-031 APPLY: after the last pixel, the next state shall be WAIT_SOF if cont=1, else IDLE.
REQ-032 acc_* shall retain their values from ACCUM exit until the next WAIT_SOF->ACCUM load.
REQ-033 Accumulators shall never wrap when ACC_W meets REQ-003; no saturation logic is required.

Reset
REQ-034 rst=1 in any state shall force IDLE, acc_*=0, pix_cnt=0, frame_cnt=0, err=0, calc_start=0, busy=0, and shall cancel any in-progress sequence.
REQ-035 rst shall override start and calc_done in the same cycle.

Verification (NROWS=4, NCOLS=4)
REQ-036 start, then 16 pixels of 0x102030 from SOF -> calc_start pulses once the cycle after pixel 16, with acc_r=0x100, acc_g=0x200, acc_b=0x300.
REQ-037 calc_done 3 cycles after calc_start, then a 16-pixel frame -> apply_en=1 on all 16 pixels including SOF, frame_done on pixel 16, frame_cnt=1, busy=0 (cont=0).
REQ-038 SOF re-asserted at pixel 7 of ACCUM -> err=1, and the sums equal only the new frame's 16 pixels.
REQ-039 cont=1, two full sequences with 0xFFFFFF pixels -> acc_*=0xFF0 each, frame_cnt=2, busy remains 1.
REQ-040 rst at pixel 9 of APPLY -> the next cycle shows IDLE, apply_en=0, frame_cnt=0, err=0, and calc_done pulses afterwards are ignored.
REQ-041 in_dval gaps (1-of-3 valid) during ACCUM -> identical sums to the gap-free run, and calc_start is delayed accordingly.
